// File: rtl/uart_write_tx.sv
// uart_write_tx: byte FIFO feeding an 8N1 UART transmitter (LSB first, txd idles high).
// Define UART_WRITE_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_write_tx #(
    parameter int unsigned CLK_DIV = 434,
    parameter int unsigned FIFO_AW = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       uart_wdata,
    input  logic             uart_write_en,
    output logic             uart_write_full,
    output logic [FIFO_AW:0] uart_write_level,
    output logic             uart_write_ovf,
    output logic             uart_write_busy,
    output logic             uart_write_fin,
    output logic             txd
);
    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam int unsigned CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] BAUD_MAX = CNT_W'(CLK_DIV - 1);

`ifdef UART_WRITE_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t state, state_n;

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   level;
    logic               ovf;
    logic               push, pop;
    logic [7:0]         head;

    logic [CNT_W-1:0]   baud_cnt, baud_n;
    logic [2:0]         bit_cnt, bit_n;
    logic [7:0]         shreg, shreg_n;
    logic               bit_end;
    logic               txd_r, txd_n;
`ifdef UART_WRITE_PARITY_EN
    logic               par_bit, par_n;
`endif

    // full comes from the registered level, so a write in the same cycle as a pop is still dropped
    assign uart_write_full  = (level == (FIFO_AW+1)'(DEPTH));
    assign uart_write_level = level;
    assign uart_write_ovf   = ovf;
    assign uart_write_busy  = (state != S_IDLE) || (level != '0);
    assign uart_write_fin   = (state == S_STOP) && bit_end;
    assign txd              = txd_r;

    assign push = uart_write_en && !uart_write_full;
    assign head = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= uart_wdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ovf    <= 1'b0;
        end else begin
            ovf <= uart_write_en && uart_write_full;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            txd_r    <= 1'b1;
`ifdef UART_WRITE_PARITY_EN
            par_bit  <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            baud_cnt <= baud_n;
            bit_cnt  <= bit_n;
            shreg    <= shreg_n;
            txd_r    <= txd_n;
`ifdef UART_WRITE_PARITY_EN
            par_bit  <= par_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        baud_n  = baud_cnt;
        bit_n   = bit_cnt;
        shreg_n = shreg;
        pop     = 1'b0;
        txd_n   = 1'b1;
`ifdef UART_WRITE_PARITY_EN
        par_n   = par_bit;
`endif
        bit_end = (baud_cnt == BAUD_MAX);

        if (state != S_IDLE) baud_n = bit_end ? '0 : baud_cnt + 1'b1;

        case (state)
            S_IDLE: begin
                if (level != '0) begin
                    pop     = 1'b1;
                    shreg_n = head;
                    baud_n  = '0;
                    state_n = S_START;
`ifdef UART_WRITE_PARITY_EN
                    par_n   = ^head;
`endif
                end
            end
            S_START: begin
                if (bit_end) begin
                    bit_n   = '0;
                    state_n = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shreg_n = {1'b0, shreg[7:1]};
                    bit_n   = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
`ifdef UART_WRITE_PARITY_EN
                        state_n = S_PARITY;
`else
                        state_n = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_WRITE_PARITY_EN
            S_PARITY: begin
                if (bit_end) state_n = S_STOP;
            end
`endif
            S_STOP: begin
                if (bit_end) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase

        // txd is registered from the next state so the line changes on the same edge as the FSM
        case (state_n)
            S_START:  txd_n = 1'b0;
            S_DATA:   txd_n = shreg_n[0];
`ifdef UART_WRITE_PARITY_EN
            S_PARITY: txd_n = par_n;
`endif
            default:  txd_n = 1'b1;
        endcase
    end

endmodule

// File: doc/uart_write_tx.md
Name: uart_write_tx

Overview:
- Transmit-side counterpart of the UART receive path, in the same single clock domain as the core.
- Core writes bytes into an internal FIFO; the block serialises them onto txd as 8N1 frames (LSB first), with an optional even-parity bit.
- Reports occupancy and overflow, and pulses once per completed frame.

Parameters:
CLK_DIV, 434, clock cycles per bit period (50 MHz / 115200); legal range is 2 or more.
FIFO_AW, 3, FIFO address width; depth = 2^FIFO_AW = 8 entries.

Ports:
clk  input  1  system clock; all logic on posedge.
rst  input  1  asynchronous, active-low reset (0 = reset).
uart_wdata  input  8  byte to transmit.
uart_write_en  input  1  one-cycle write strobe for uart_wdata.
uart_write_full  output  1  FIFO holds 2^FIFO_AW entries.
uart_write_level  output  FIFO_AW+1  current FIFO occupancy.
uart_write_ovf  output  1  one-cycle pulse when a write is dropped.
uart_write_busy  output  1  high when FSM is not IDLE or FIFO is non-empty.
uart_write_fin  output  1  one-cycle pulse in the last clock of each stop bit.
txd  output  1  serial line; idles high.

Behaviour:
- Reset (asynchronous assert, registered release):
  - txd=1; full=0; level=0; ovf=0; busy=0; fin=0.
  - FSM=IDLE; FIFO pointers, baud counter and bit counter all cleared.
- Reset mid-frame: the frame is aborted immediately and txd returns to 1 asynchronously. FIFO contents are lost.
- FIFO write:
  - A write is accepted when uart_write_en=1 and full=0 (full taken from its registered pre-edge value).
  - When a write arrives while full=1, the data is dropped and ovf pulses on the next cycle. This holds even if a pop happens in the same cycle.
  - A push and a pop in the same cycle leave level unchanged.
  - Pointers wrap modulo 2^FIFO_AW. Level counts 0..2^FIFO_AW.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - txd=1.
  - If level!=0: pop the head into an 8-bit shift register, clear the baud counter, go to START.
  - A byte written while the FIFO is empty is seen by IDLE one cycle after the write (write-to-start-bit latency is 2 clocks).
- Bit timing: each bit (START, DATA bits, optional parity, STOP) drives txd for exactly CLK_DIV clocks. The baud counter runs 0..CLK_DIV-1, and the state/bit advances when the counter equals CLK_DIV-1.
- START: txd=0. Then go to DATA with bit counter=0.
- DATA:
  - txd = shift register bit 0.
  - At the end of each bit, shift right and increment the bit counter.
  - After bit 7, go to STOP.
- STOP:
  - txd=1.
  - fin=1 when the counter equals CLK_DIV-1.
  - Then go to IDLE.
  - Back-to-back frames therefore have a stop bit of CLK_DIV+1 clocks (the extra clock is the IDLE cycle).
- txd is registered: no combinational path from any input to txd.
- busy is combinational from the FSM state and level. The core must not deassert its clock domain or sleep while busy=1.

Optional Feature:
Macro UART_WRITE_PARITY_EN.
- Defined:
  - A PARITY state sits between DATA and STOP.
  - txd = XOR of the 8 data bits (even parity) for CLK_DIV clocks.
  - Frame is 11 bit periods.
- Undefined:
  - The PARITY state and its logic are absent.
  - DATA goes directly to STOP; frame is 10 bit periods.

Test Plan (CLK_DIV=4, FIFO_AW=3, parity off unless stated):
- Reset held low with writes toggling -> txd=1, level=0, busy=0 throughout; after release, first write 0x55 starts START 2 clocks later.
- Write 0xA5 once -> txd pattern per 4 clocks: 0,1,0,1,0,0,1,0,1,1; fin pulses once at clock 39 after the start bit began; level returns to 0.
- Write 9 bytes 0x00..0x08 on consecutive cycles -> the first byte is popped after 2 clocks, so none is dropped; level peaks at 8 with full=1; all 9 bytes transmitted in order.
- Write 12 bytes on consecutive cycles -> exactly 3 ovf pulses; the 9 transmitted bytes are the first 9 written.
- Assert rst low at clock 17 of a 0xFF frame, release 3 clocks later -> txd=1 immediately, FIFO empty, no fin, next written byte is transmitted cleanly.
- UART_WRITE_PARITY_EN defined: write 0x07 -> parity bit 1; write 0x03 -> parity bit 0; frame is 44 clocks, with fin in the last clock.
